gray_conv_arbiter: RTL and testbench



---
 rtl/gray_conv_arbiter.sv | 101 ++++++++++
 tb/tb_gray_conv_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that shares one registered Gray-to-binary converter among
// NREQ requesters and returns the result with the winner's ID on a valid/ready port.
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] gray_in,
  output logic [NREQ-1:0]       ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id,
  output logic                  busy,
  output logic [CNTW-1:0]       conv_count
);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic             found;
  logic [WIDTH-1:0] cap;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (int'(id) == NREQ - 1) ? '0 : id + IDW'(1);
  endfunction

  // First set request at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack        <= '0;
      out_valid  <= 1'b0;
      out_bin    <= '0;
      out_id     <= '0;
      busy       <= 1'b0;
      conv_count <= '0;
      ptr        <= '0;
      cap        <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            cap      <= gray_in[win*WIDTH +: WIDTH];
            out_id   <= win;
            ack[win] <= 1'b1;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          out_bin   <= gray2bin(cap);
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          // Result, ID and valid stay frozen until the consumer takes them.
          if (out_ready) begin
            out_valid  <= 1'b0;
            ptr        <= next_id(out_id);
            conv_count <= conv_count + CNTW'(1);
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter: grant order, conversion,
// backpressure, pointer wrap, asynchronous reset and counter wrap.
module tb_gray_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] gray_in;
  logic [3:0]  ack;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_bin;
  logic [1:0]  out_id;
  logic        busy;
  logic [7:0]  conv_count;

  logic [3:0]  ack4;
  logic        out_valid4;
  logic [3:0]  out_bin4;
  logic [1:0]  out_id4;
  logic        busy4;
  logic [3:0]  conv_count4;

  int ntests = 0;
  int nfail  = 0;
  int exp_cnt = 0;

  // Hand-computed binary value of each 4-bit Gray code 0..15.
  logic [3:0] bin_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                               4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};

  always #5 clk = ~clk;

  gray_conv_arbiter #(.WIDTH(4), .NREQ(4), .IDW(2), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gray_in(gray_in), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_id(out_id), .busy(busy), .conv_count(conv_count)
  );

  gray_conv_arbiter #(.WIDTH(4), .NREQ(4), .IDW(2), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .gray_in(gray_in), .ack(ack4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_bin(out_bin4),
    .out_id(out_id4), .busy(busy4), .conv_count(conv_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset asserted and released in the clock-low phase, away from any edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  // Called at a negedge with req already set so that requester w wins at the
  // next rising edge; out_ready is expected high.
  task automatic grant(input int w, input logic [3:0] eb, input string tag);
    @(negedge clk);
    chk({tag, "_ack"}, ack, 32'(4'b0001 << w));
    chk({tag, "_busy"}, busy, 1);
    req[w] = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_bin"}, out_bin, eb);
    chk({tag, "_id"}, out_id, w);
    chk({tag, "_ack0"}, ack, 0);
    exp_cnt++;
    @(negedge clk);
    chk({tag, "_valid0"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_cnt"}, conv_count, exp_cnt);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    gray_in   = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", conv_count, 0);
    chk("rst_bin", out_bin, 0);
    chk("rst_id", out_id, 0);
    #4 rst_n = 1'b1;

    // Single request on requester 0, Gray 1101 -> 1001.
    @(negedge clk);
    gray_in[3:0] = 4'b1101;
    req = 4'b0001;
    grant(0, 4'b1001, "single");

    // All four requesters, each re-raising after service.
    do_reset();
    gray_in = {4'b1111, 4'b1000, 4'b0110, 4'b0000};
    req = 4'b1111;
    grant(0, 4'b0000, "rr0");  req[0] = 1'b1;
    grant(1, 4'b0100, "rr1");  req[1] = 1'b1;
    grant(2, 4'b1111, "rr2");  req[2] = 1'b1;
    grant(3, 4'b1010, "rr3");  req[3] = 1'b1;
    grant(0, 4'b0000, "rr4");
    req = '0;

    // Backpressure on requester 1 with Gray 0110; input changes must not leak in.
    @(negedge clk);
    chk("bp_pre_idle", busy, 0);
    out_ready = 1'b0;
    gray_in[7:4] = 4'b0110;
    req = 4'b0010;
    @(negedge clk);
    chk("bp_ack", ack, 4'b0010);
    req = '0;
    @(negedge clk);
    chk("bp_valid", out_valid, 1);
    gray_in[7:4] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_bin", out_bin, 4'b0100);
      chk("bp_hold_id", out_id, 1);
      chk("bp_hold_ack", ack, 0);
    end
    out_ready = 1'b1;
    exp_cnt++;
    @(negedge clk);
    chk("bp_done_valid", out_valid, 0);
    chk("bp_done_cnt", conv_count, exp_cnt);

    // Pointer wrap: serve 2, then 0101 must grant 0, then 0101 again grants 2.
    gray_in = {4'b0000, 4'b1010, 4'b0000, 4'b0011};
    req = 4'b0100;
    grant(2, 4'b1100, "ptr_a");
    req = 4'b0101;
    grant(0, 4'b0010, "ptr_wrap");
    req[0] = 1'b1;
    grant(2, 4'b1100, "ptr_next");
    req = '0;

    // Asynchronous reset in HOLD; pointer (then 3) must return to 0.
    gray_in[15:12] = 4'b0001;
    req = 4'b1000;
    @(negedge clk);
    chk("ar_ack", ack, 4'b1000);
    req = '0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("ar_hold", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ack0", ack, 0);
    chk("ar_busy", busy, 0);
    chk("ar_cnt", conv_count, 0);
    #1 rst_n = 1'b1;
    exp_cnt = 0;
    out_ready = 1'b1;
    gray_in = {4'b0001, 4'b0000, 4'b0011, 4'b0000};
    @(negedge clk);
    req = 4'b1010;
    grant(1, 4'b0010, "ar_ptr0");
    grant(3, 4'b0001, "ar_next");

    // Every Gray code through requester 1; the CNTW=4 copy wraps to 0.
    do_reset();
    for (int g = 0; g < 16; g++) begin
      gray_in[7:4] = 4'(g);
      req = 4'b0010;
      grant(1, bin_tab[g], "exh");
    end
    chk("exh_cnt16", conv_count, 16);
    chk("exh_wrap4", conv_count4, 0);
    chk("exh_bin4", out_bin4, 4'b1010);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
